// File: rtl/br_stat_pkg.sv
// Shared constants and encodings for the branch-prediction statistics unit.
// Counter index layout: three counters per branch type, then stage errors, then total mispredicts.
package br_stat_pkg;

    localparam int CNT_PER_TYPE = 3;
    localparam int OFS_TOTAL    = 0;
    localparam int OFS_DIR      = 1;
    localparam int OFS_TGT      = 2;

    typedef enum logic [1:0] {
        STG_ID  = 2'd0,
        STG_EXE = 2'd1,
        STG_MEM = 2'd2
    } err_stage_e;

    // Branch classes as encoded by the predictor on br_type.
    typedef enum logic [2:0] {
        BR_COND     = 3'd0,
        BR_JAL      = 3'd1,
        BR_JALR     = 3'd2,
        BR_CALL     = 3'd3,
        BR_RET      = 3'd4,
        BR_IND_CALL = 3'd5,
        BR_IND_JMP  = 3'd6,
        BR_OTHER    = 3'd7
    } br_type_e;

    function automatic int stage_base(input int num_br_types);
        return CNT_PER_TYPE * num_br_types;
    endfunction

    function automatic int misp_idx(input int num_br_types, input int num_err_stages);
        return stage_base(num_br_types) + num_err_stages;
    endfunction

    localparam int STAGE_BASE = stage_base(8);
    localparam int MISP_IDX   = misp_idx(8, 3);

endpackage

// File: rtl/br_sat_cnt.sv
// Single saturating event counter with synchronous clear and count enable.
// sat_hit flags an increment that was swallowed because the counter is already full.
module br_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] value,
    output logic             sat_hit
);

    logic [CNT_W-1:0] r_value;
    logic             w_at_max;

    assign w_at_max = &r_value;
    assign sat_hit  = en & inc & ~clr & w_at_max;
    assign value    = r_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
        end else if (clr) begin
            r_value <= '0;
        end else if (en && inc && !w_at_max) begin
            r_value <= r_value + 1'b1;
        end
    end

endmodule

// File: rtl/br_stat_counter.sv
// Branch-prediction statistics: saturating per-type / per-stage counters behind a registered read port.
// A read returns the counter value from before the edge that samples rd_en.
module br_stat_counter
    import br_stat_pkg::*;
#(
    parameter  int NUM_BR_TYPES   = 8,
    parameter  int NUM_ERR_STAGES = 3,
    parameter  int ADDR_XLEN      = 32,
    parameter  int CNT_W          = 32,
    parameter  int RD_ADDR_W      = $clog2(3*NUM_BR_TYPES+NUM_ERR_STAGES+1),
    localparam int BT_W           = (NUM_BR_TYPES > 1) ? $clog2(NUM_BR_TYPES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      br_valid,
    input  logic [BT_W-1:0]           br_type,
    input  logic                      pre_taken,
    input  logic [ADDR_XLEN-1:0]      pre_target,
    input  logic                      true_taken,
    input  logic [ADDR_XLEN-1:0]      true_target,
    input  logic [NUM_ERR_STAGES-1:0] stage_err,
    input  logic                      cnt_en,
    input  logic                      clr,
    input  logic                      rd_en,
    input  logic [RD_ADDR_W-1:0]      rd_addr,
    output logic                      rd_valid,
    output logic [CNT_W-1:0]          rd_data,
    output logic                      ovf
);

    localparam int STB     = stage_base(NUM_BR_TYPES);
    localparam int MISP    = misp_idx(NUM_BR_TYPES, NUM_ERR_STAGES);
    localparam int NUM_CNT = MISP + 1;

    logic                  w_dir_miss;
    logic                  w_tgt_miss;
    logic                  w_misp;
    logic [NUM_CNT-1:0]    w_inc;
    logic [NUM_CNT-1:0]    w_sat;
    logic [CNT_W-1:0]      w_cnt [NUM_CNT];
    logic [CNT_W-1:0]      w_rd_mux;
    logic                  r_rd_valid;
    logic [CNT_W-1:0]      r_rd_data;
    logic                  r_ovf;

    assign w_dir_miss = pre_taken ^ true_taken;
    assign w_tgt_miss = pre_taken & true_taken & (pre_target != true_target);
    assign w_misp     = w_dir_miss | w_tgt_miss;

    // Out-of-range branch types match no per-type slot but still reach the mispredict total.
    always_comb begin
        w_inc = '0;
        for (int t = 0; t < NUM_BR_TYPES; t++) begin
            if (br_valid && (br_type == BT_W'(t))) begin
                w_inc[CNT_PER_TYPE*t + OFS_TOTAL] = 1'b1;
                w_inc[CNT_PER_TYPE*t + OFS_DIR]   = w_dir_miss;
                w_inc[CNT_PER_TYPE*t + OFS_TGT]   = w_tgt_miss;
            end
        end
        for (int s = 0; s < NUM_ERR_STAGES; s++) begin
            w_inc[STB + s] = stage_err[s];
        end
        w_inc[MISP] = br_valid & w_misp;
    end

    for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
        br_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst_n   (rst_n),
            .inc     (w_inc[gi]),
            .clr     (clr),
            .en      (cnt_en),
            .value   (w_cnt[gi]),
            .sat_hit (w_sat[gi])
        );
    end

    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_addr == RD_ADDR_W'(i)) begin
                w_rd_mux = w_cnt[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_mux;
            end
            if (clr) begin
                r_ovf <= 1'b0;
            end else if (|w_sat) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_br_stat_counter.sv
// Bench for br_stat_counter: a full-size instance and a narrow one (4-bit counters, 6 types)
// share stimulus and are scored against an event-level reference model.
module tb_br_stat_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid, pre_taken, true_taken, cnt_en, clr, rd_en;
    logic [2:0]  br_type, stage_err;
    logic [31:0] pre_target, true_target;
    logic [4:0]  rd_addr;
    logic        rd_valid_a, ovf_a, rd_valid_b, ovf_b;
    logic [31:0] rd_data_a;
    logic [3:0]  rd_data_b;

    always #5 clk = ~clk;

    br_stat_counter #(.NUM_BR_TYPES(8), .NUM_ERR_STAGES(3), .ADDR_XLEN(32), .CNT_W(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_type(br_type),
        .pre_taken(pre_taken), .pre_target(pre_target), .true_taken(true_taken),
        .true_target(true_target), .stage_err(stage_err), .cnt_en(cnt_en), .clr(clr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_a), .rd_data(rd_data_a), .ovf(ovf_a)
    );

    br_stat_counter #(.NUM_BR_TYPES(6), .NUM_ERR_STAGES(3), .ADDR_XLEN(32), .CNT_W(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_type(br_type),
        .pre_taken(pre_taken), .pre_target(pre_target), .true_taken(true_taken),
        .true_target(true_target), .stage_err(stage_err), .cnt_en(cnt_en), .clr(clr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid_b), .rd_data(rd_data_b), .ovf(ovf_b)
    );

    // Reference model: index 0 = full-size instance, 1 = narrow instance.
    longint unsigned m_cnt [2][32];
    longint unsigned m_max [2] = '{64'hFFFF_FFFF, 64'd15};
    int              m_nt  [2] = '{8, 6};
    int              m_nc  [2] = '{28, 22};
    bit              m_ovf [2];

    logic [31:0] exp_q_a[$];
    logic [3:0]  exp_q_b[$];
    logic [31:0] last_a;
    logic [3:0]  last_b;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 32; i++) m_cnt[w][i] = 0;
            m_ovf[w] = 1'b0;
        end
    endtask

    task automatic bump(input int w, input int idx);
        if (m_cnt[w][idx] == m_max[w]) m_ovf[w] = 1'b1;
        else m_cnt[w][idx] = m_cnt[w][idx] + 1;
    endtask

    function automatic longint unsigned read_model(input int w, input int addr);
        return (addr < m_nc[w]) ? m_cnt[w][addr] : 64'd0;
    endfunction

    task automatic model_edge();
        bit dir, tgt;
        int t;
        if (clr) begin
            model_clear();
            return;
        end
        if (!cnt_en) return;
        dir = (pre_taken != true_taken);
        tgt = pre_taken && true_taken && (pre_target != true_target);
        t   = int'(br_type);
        for (int w = 0; w < 2; w++) begin
            if (br_valid) begin
                if (t < m_nt[w]) begin
                    bump(w, 3*t);
                    if (dir) bump(w, 3*t + 1);
                    if (tgt) bump(w, 3*t + 2);
                end
                if (dir || tgt) bump(w, m_nc[w] - 1);
            end
            for (int s = 0; s < 3; s++) begin
                if (stage_err[s]) bump(w, 3*m_nt[w] + s);
            end
        end
    endtask

    task automatic tick();
        logic exp_v;
        exp_v = rd_en;
        if (rd_en) begin
            exp_q_a.push_back(32'(read_model(0, int'(rd_addr))));
            exp_q_b.push_back(4'(read_model(1, int'(rd_addr))));
        end
        model_edge();
        @(posedge clk);
        #1;
        check("rd_valid_a", 64'(rd_valid_a), 64'(exp_v));
        check("rd_valid_b", 64'(rd_valid_b), 64'(exp_v));
        if (exp_v) begin
            last_a = exp_q_a.pop_front();
            last_b = exp_q_b.pop_front();
        end
        check("rd_data_a", 64'(rd_data_a), 64'(last_a));
        check("rd_data_b", 64'(rd_data_b), 64'(last_b));
        check("ovf_a", 64'(ovf_a), 64'(m_ovf[0]));
        check("ovf_b", 64'(ovf_b), 64'(m_ovf[1]));
    endtask

    task automatic idle();
        br_valid = 1'b0; br_type = 3'd0; pre_taken = 1'b0; true_taken = 1'b0;
        pre_target = 32'd0; true_target = 32'd0; stage_err = 3'd0;
        cnt_en = 1'b1; clr = 1'b0; rd_en = 1'b0; rd_addr = 5'd0;
    endtask

    task automatic set_br(input logic [2:0] t, input logic pt, input logic [31:0] ptgt,
                          input logic tt, input logic [31:0] ttgt);
        br_valid = 1'b1; br_type = t; pre_taken = pt; pre_target = ptgt;
        true_taken = tt; true_target = ttgt;
    endtask

    // Reads one index back and also checks the full-size (and optionally narrow) value against a literal.
    task automatic read_expect(input int addr, input longint unsigned exp_a, input int exp_b = -1);
        idle();
        rd_en = 1'b1;
        rd_addr = 5'(addr);
        tick();
        rd_en = 1'b0;
        check($sformatf("lit_a[%0d]", addr), 64'(rd_data_a), 64'(exp_a));
        if (exp_b >= 0) check($sformatf("lit_b[%0d]", addr), 64'(rd_data_b), 64'(exp_b));
    endtask

    task automatic read_all();
        idle();
        for (int i = 0; i < 32; i++) begin
            rd_en = 1'b1;
            rd_addr = 5'(i);
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        model_clear();
        last_a = '0;
        last_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_valid", 64'(rd_valid_a | rd_valid_b), 64'd0);
        check("reset_ovf", 64'(ovf_a | ovf_b), 64'd0);
        check("reset_rd_data", 64'(rd_data_a), 64'd0);
        rst_n = 1'b1;
        tick();
        read_all();

        // Type-2 direction mispredicts.
        for (int i = 0; i < 5; i++) begin
            idle(); set_br(3'd2, 1'b1, 32'h100, 1'b0, 32'h100); tick();
        end
        read_expect(6, 5, 5); read_expect(7, 5, 5); read_expect(8, 0, 0); read_expect(27, 5);

        // Type-1 target mispredicts.
        for (int i = 0; i < 3; i++) begin
            idle(); set_br(3'd1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0020); tick();
        end
        read_expect(3, 3, 3); read_expect(4, 0, 0); read_expect(5, 3, 3); read_expect(27, 8);

        // ID and MEM stage errors alongside correct type-0 branches.
        for (int i = 0; i < 4; i++) begin
            idle(); set_br(3'd0, 1'b0, 32'h40, 1'b0, 32'h80); stage_err = 3'b101; tick();
        end
        read_expect(24, 4); read_expect(25, 0); read_expect(26, 4);
        read_expect(0, 4, 4); read_expect(1, 0, 0); read_expect(18, 0, 4);

        // Saturation of the narrow instance, then clear racing a branch and a read.
        idle(); clr = 1'b1; tick();
        for (int i = 0; i < 17; i++) begin
            idle(); set_br(3'd0, 1'b1, 32'h44, 1'b1, 32'h44); tick();
        end
        read_expect(0, 17, 15);
        check("sat_ovf_b", 64'(ovf_b), 64'd1);
        check("sat_ovf_a", 64'(ovf_a), 64'd0);
        idle(); set_br(3'd0, 1'b1, 32'h44, 1'b1, 32'h44); clr = 1'b1; rd_en = 1'b1; rd_addr = 5'd0;
        tick();
        check("clr_read_pre_a", 64'(rd_data_a), 64'd17);
        check("clr_read_pre_b", 64'(rd_data_b), 64'd15);
        read_expect(0, 0, 0);
        check("clr_ovf_b", 64'(ovf_b), 64'd0);

        // Freeze, then out-of-range and unmapped-type behaviour.
        for (int i = 0; i < 2; i++) begin
            idle(); set_br(3'd3, 1'b0, 32'h0, 1'b1, 32'h200); tick();
        end
        for (int i = 0; i < 10; i++) begin
            idle(); set_br(3'($urandom_range(0, 7)), 1'b1, $urandom, 1'b0, $urandom);
            stage_err = 3'b111; cnt_en = 1'b0; tick();
        end
        read_expect(9, 2, 2); read_expect(10, 2, 2); read_expect(27, 2); read_expect(21, 0, 2);
        read_expect(24, 0); read_expect(28, 0, 0); read_expect(23, 0, 0); read_expect(31, 0, 0);
        idle(); set_br(3'd7, 1'b1, 32'h10, 1'b0, 32'h10); tick();
        read_expect(21, 1, 3); read_expect(22, 1, 0); read_expect(27, 3, 0);
        read_all();

        // Randomised traffic.
        for (int i = 0; i < 600; i++) begin
            br_valid    = 1'($urandom_range(0, 1));
            br_type     = 3'($urandom_range(0, 7));
            pre_taken   = 1'($urandom_range(0, 1));
            true_taken  = 1'($urandom_range(0, 1));
            pre_target  = $urandom;
            true_target = ($urandom_range(0, 1) == 0) ? pre_target : $urandom;
            stage_err   = 3'($urandom_range(0, 7));
            cnt_en      = ($urandom_range(0, 9) != 0);
            clr         = ($urandom_range(0, 59) == 0);
            rd_en       = 1'($urandom_range(0, 1));
            rd_addr     = 5'($urandom_range(0, 31));
            tick();
        end
        read_all();

        // Reset while a read is in flight.
        idle(); set_br(3'd2, 1'b1, 32'h0, 1'b0, 32'h0); stage_err = 3'b111; tick();
        rd_en = 1'b1; rd_addr = 5'd6;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rd_valid", 64'(rd_valid_a | rd_valid_b), 64'd0);
        check("rst_mid_rd_data", 64'(rd_data_a), 64'd0);
        check("rst_mid_ovf", 64'(ovf_a | ovf_b), 64'd0);
        model_clear();
        exp_q_a.delete();
        exp_q_b.delete();
        last_a = '0;
        last_b = '0;
        idle();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        read_expect(6, 0, 0); read_expect(26, 0);
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
